// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited arbiter for the FIFO write port
// Ports: w_clk/rst (async active-low); req_valid/req_data from producers, req_ready back;
// full_flag from the FIFO; data_in/w_inc to storage and write pointer; grant_id/busy status.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      w_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      full_flag,
  output logic [DATA_W-1:0]         data_in,
  output logic                      w_inc,
  output logic [1:0]                grant_id,
  output logic                      busy
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [3:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] mask;
  logic g_valid, xfer, rel;
  // scanned from farthest to nearest so the nearest candidate after base wins
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] m, input logic [1:0] base);
    rr_pick = base;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [1:0] idx;
      idx = 2'((int'(base) + k) % NUM_REQ);
      if (m[idx]) rr_pick = idx;
    end
  endfunction
  assign g_valid = req_valid[grant_q];
  assign xfer    = (state_q == OWN) && g_valid && !full_flag;
  assign rel     = (state_q == OWN) && (!g_valid || (xfer && cnt_q == 4'(MAX_BURST - 1)));
  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  // while owning, last_q equals grant_q, so one scan base serves both arbitration points
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    mask    = req_valid;
    if (state_q == OWN && !g_valid) mask[grant_q] = 1'b0;
    pick = rr_pick(mask, last_q);
    if (state_q == IDLE || rel) begin
      state_d = |mask ? OWN : IDLE;
      grant_d = |mask ? pick : grant_q;
      last_d  = |mask ? pick : last_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 4'(xfer);
    end
  end
  always_comb begin
    req_ready = xfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    w_inc     = xfer;
    data_in   = (state_q == OWN) ? req_data[grant_q*DATA_W +: DATA_W] : '0;
    grant_id  = grant_q;
    busy      = (state_q == OWN);
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized and directed bench with a behavioural arbitration model
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MB = 4;
  logic w_clk = 0, rst = 0, full_flag = 0, w_inc, busy;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [W-1:0] data_in;
  logic [1:0] grant_id;
  int n_cmp = 0, n_bad = 0;
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .w_clk(w_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .full_flag(full_flag), .data_in(data_in),
    .w_inc(w_inc), .grant_id(grant_id), .busy(busy));
  always #5 w_clk = ~w_clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: who owns the port, where round-robin resumes, words taken in this grant
  bit m_own = 0, n_own = 0;
  logic [1:0] m_g = 0, m_last = 3, n_g = 0, n_last = 3;
  int m_cnt = 0, n_cnt = 0;
  logic [N-1:0] m_rdy_s = '0;
  typedef struct {bit w; logic [1:0] g;} ent_t;
  ent_t log_q[$];
  int wpos[$];
  logic [1:0] wg[$];
  always @(negedge w_clk) begin
    if (!rst) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_winc", 32'(w_inc), 0);
      chk("rst_data", 32'(data_in), 0);
      chk("rst_busy", 32'(busy), 0);
      m_rdy_s = '0;
      n_own = 0; n_g = 0; n_last = 3; n_cnt = 0;
    end else begin
      bit x, rel;
      logic [N-1:0] e_rdy, mask;
      logic [W-1:0] e_data;
      int win;
      x = m_own && req_valid[m_g] && !full_flag;
      e_rdy = '0;
      if (x) e_rdy[m_g] = 1'b1;
      e_data = m_own ? req_data[m_g*W +: W] : '0;
      chk("ready", 32'(req_ready), 32'(e_rdy));
      chk("winc", 32'(w_inc), 32'(x));
      chk("data", 32'(data_in), 32'(e_data));
      chk("grant", 32'(grant_id), 32'(m_g));
      chk("busy", 32'(busy), 32'(m_own));
      m_rdy_s = e_rdy;
      log_q.push_back('{x, m_g});
      rel = m_own && (!req_valid[m_g] || (x && m_cnt == MB - 1));
      n_own = m_own; n_g = m_g; n_last = m_last; n_cnt = m_cnt + int'(x);
      if (!m_own || rel) begin
        mask = req_valid;
        if (m_own && !req_valid[m_g]) mask[m_g] = 1'b0;
        win = -1;
        for (int k = 1; k <= N; k++) begin
          logic [1:0] c;
          c = 2'((int'(m_last) + k) % N);
          if (win < 0 && mask[c]) win = int'(c);
        end
        n_cnt = 0;
        n_own = (win >= 0);
        if (win >= 0) begin n_g = 2'(win); n_last = 2'(win); end
      end
    end
  end
  always @(posedge w_clk or negedge rst) begin
    if (!rst) begin m_own = 0; m_g = 0; m_last = 3; m_cnt = 0; end
    else begin m_own = n_own; m_g = n_g; m_last = n_last; m_cnt = n_cnt; end
  end
  // producers: rem words left each, data tagged {producer, sequence}
  int rem[N];
  logic [5:0] seq[N];
  bit rnd_mode = 0;
  function automatic void apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rem[i] > 0 && (!rnd_mode || $urandom_range(0, 3) != 0);
      req_data[i*W +: W] = {2'(i), seq[i]};
    end
  endfunction
  task automatic tick();
    @(posedge w_clk); #1;
    for (int i = 0; i < N; i++) if (m_rdy_s[i]) begin rem[i]--; seq[i]++; end
    apply();
  endtask
  task automatic drain(input int maxc);
    int n = 0;
    while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && n < maxc) begin tick(); n++; end
    chk("drain_timeout", 32'(rem[0] + rem[1] + rem[2] + rem[3]), 0);
    repeat (3) tick();
  endtask
  function automatic void collect();
    wpos.delete(); wg.delete();
    foreach (log_q[i]) if (log_q[i].w) begin wpos.push_back(i); wg.push_back(log_q[i].g); end
  endfunction
  initial begin
    logic [1:0] exp4[9];
    for (int i = 0; i < N; i++) begin rem[i] = 8; seq[i] = 1; end
    apply();
    repeat (3) @(posedge w_clk);
    #1;
    chk("hold_rst_winc", 32'(w_inc), 0);
    chk("hold_rst_busy", 32'(busy), 0);
    chk("hold_rst_gid", 32'(grant_id), 0);
    rst = 1;
    log_q.delete();
    tick();
    chk("first_gid", 32'(grant_id), 0);
    chk("first_busy", 32'(busy), 1);
    chk("first_winc", 32'(w_inc), 1);
    chk("first_data", 32'(data_in), 32'h01);
    drain(200);
    collect();
    chk("burst_words", 32'(wpos.size()), 32);
    chk("burst_start", 32'(wpos[0]), 1);
    chk("burst_nogap", 32'(wpos[15] - wpos[0]), 15);
    for (int j = 0; j < 5; j++) chk($sformatf("burst_order%0d", j), 32'(wg[j*4]), 32'(j % 4));
    for (int j = 0; j < 16; j++) if (wg[j] != wg[(j/4)*4]) chk("burst_len", 32'(wg[j]), 32'(wg[(j/4)*4]));
    log_q.delete();
    rem[1] = 2;
    apply();
    drain(50);
    collect();
    chk("early_words", 32'(wpos.size()), 2);
    chk("early_gid", 32'(wg[0]), 1);
    chk("early_idle", 32'(busy), 0);
    log_q.delete();
    rem[2] = 6; rem[3] = 3;
    apply();
    for (int n = 0; n < 50 && rem[2] != 4; n++) tick();
    chk("wait_p2", 32'(rem[2]), 4);
    full_flag = 1;
    repeat (5) tick();
    full_flag = 0;
    drain(100);
    collect();
    exp4 = '{2, 2, 2, 2, 3, 3, 3, 2, 2};
    chk("full_words", 32'(wpos.size()), 9);
    for (int j = 0; j < 9 && j < wg.size(); j++) chk($sformatf("full_seq%0d", j), 32'(wg[j]), 32'(exp4[j]));
    if (wpos.size() >= 4) begin
      chk("full_gap", 32'(wpos[2] - wpos[1]), 6);
      chk("full_resume", 32'(wpos[3] - wpos[2]), 1);
    end
    log_q.delete();
    rem[3] = 10;
    apply();
    drain(100);
    collect();
    chk("sole_words", 32'(wpos.size()), 10);
    if (wpos.size() == 10) chk("sole_b2b", 32'(wpos[9] - wpos[0]), 9);
    foreach (wg[j]) if (wg[j] != 2'd3) chk("sole_gid", 32'(wg[j]), 3);
    rem[0] = 5;
    apply();
    for (int n = 0; n < 50 && rem[0] != 4; n++) tick();
    chk("wait_p0", 32'(rem[0]), 4);
    rst = 0;
    #1;
    chk("mid_rst_winc", 32'(w_inc), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_data", 32'(data_in), 0);
    chk("mid_rst_gid", 32'(grant_id), 0);
    repeat (2) tick();
    rem[1] = 3;
    rst = 1;
    apply();
    tick();
    chk("post_rst_pick", 32'(grant_id), 0);
    drain(100);
    rnd_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = $urandom_range(1, 9);
      full_flag = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) begin rst = 0; tick(); rst = 1; end
      tick();
    end
    rnd_mode = 0;
    full_flag = 0;
    apply();
    drain(500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin write-port arbiter for the 16x8 FIFO storage in the write clock domain.
- Up to NUM_REQ producers share the single FIFO write port; each winner may write a bounded burst before the grant rotates.
- Drives the storage write data and the write-pointer increment; obeys the synchronized full flag.
- Sits between producer blocks and the FIFO write-pointer/storage logic.

## Interface
Parameters:
- NUM_REQ, 4: number of producers (2..4; grant_id is 2 bits).
- DATA_W, 8: data width; matches FIFO word.
- MAX_BURST, 4: max words per grant (1..15).

Ports:
- w_clk  in  1  write-domain clock; all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  producer i has a word.
- req_data  in  NUM_REQ*DATA_W  producer i word at bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  word of producer i is accepted this cycle.
- full_flag  in  1  FIFO full, already synchronized to w_clk.
- data_in  out  DATA_W  word to FIFO storage.
- w_inc  out  1  advance write pointer; one word committed this cycle.
- grant_id  out  2  index of current grant holder.
- busy  out  1  a grant is held (state OWN).

## Operation
- States: IDLE (no grant), OWN (grant to g = grant_id). Registers: state, grant_id, last (last granted index), burst_cnt (4 bits).
- Reset: IDLE, grant_id=0, last=NUM_REQ-1, burst_cnt=0, so first priority order is 0,1,2,3.
- Round-robin pick: first i with req_valid[i] scanning last+1, last+2, ... wrapping, ending with last itself.
- IDLE: if any req_valid, at the edge go OWN, grant_id=pick, last=pick, burst_cnt=0; else stay.
- OWN transfer condition xfer = req_valid[g] & !full_flag (combinational).
- On xfer: req_ready[g]=1, w_inc=1, data_in=req_data[g]; burst_cnt increments at the edge.
- Release at the edge when req_valid[g]=0, or when xfer and burst_cnt==MAX_BURST-1.
- On release: if any req_valid (sampled that cycle, excluding g when g dropped valid), re-arbitrate immediately from last=g into OWN with burst_cnt=0; else go IDLE.
- Burst exhausted with only g valid: g is re-granted, burst_cnt=0; no idle cycle.
- full_flag=1 in OWN: no xfer, req_ready all 0, w_inc=0, burst_cnt and grant held.
- Non-granted producers: req_ready always 0.
- data_in = req_data[g] in OWN (even with full), 0 in IDLE; FIFO samples it only when not full.

## Timing
- Outputs req_ready, w_inc, data_in are combinational from registered state plus req_valid/full_flag; grant_id, busy are registered.
- Reset values: req_ready=0, w_inc=0, data_in=0, grant_id=0, busy=0.
- Latency: req_valid rising in cycle N from IDLE -> grant at edge ending N -> first w_inc in cycle N+1.
- Sustained throughput: one word per cycle across grant switches (re-arbitration costs no cycle).
- At most one w_inc per cycle; w_inc and req_ready[g] are always equal.
- Reset asserted mid-burst: immediate return to reset values; partial bursts are not resumed.
- full_flag rise and fall take effect in the same cycle (no registering).

## Test plan
- Reset: hold rst=0 with req_valid=4'b1111 -> all outputs 0, busy=0; release -> grant_id=0 one edge later, then w_inc=1 with data_in=req_data[0].
- Burst limit, MAX_BURST=4, all four valid continuously with distinct data -> grant order 0,1,2,3,0, exactly 4 w_inc per grant, 16 consecutive w_inc cycles with no gaps.
- Early release: producer 1 valid for 2 words only, others idle -> 2 w_inc, then IDLE (busy=0) on next edge.
- Full stall: mid-burst after 2 words on producer 2, full_flag=1 for 5 cycles -> w_inc=0, req_ready=0, burst_cnt holds; after deassert exactly 2 more words, then rotate.
- Sole requester: only producer 3 valid for 10 words -> 10 back-to-back w_inc, grant_id stays 3, burst_cnt wraps 0..3.
- Reset mid-burst: assert rst after 1 word of producer 0 -> outputs 0 immediately; after release, first pick is producer 0 again.
